// File: rtl/bp_pkg.sv
// Shared constants and types for the dynamic branch predictor / BTB.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int unsigned TGT_W = 30;

  typedef enum logic {
    BP_IDLE = 1'b0,
    BP_INIT = 1'b1
  } bp_state_e;

  function automatic int unsigned bp_iw(input int unsigned entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter next-state function; used for the 2-bit
// direction counters and the wide performance counters.
module bp_sat_ctr #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] nxt_c
);

  always_comb begin
    nxt_c = cnt_i;
    if (inc_i && !dec_i && (cnt_i != {W{1'b1}})) begin
      nxt_c = cnt_i + W'(1);
    end else if (dec_i && !inc_i && (cnt_i != '0)) begin
      nxt_c = cnt_i - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare direction predictor with BTB, combinational IF lookup,
// ID-stage update port, invalidate walker and saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned GHR_BITS = 0,
  parameter int unsigned STAT_W   = 32,
  localparam int unsigned IW      = bp_iw(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       lk_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [IW-1:0]     pred_idx,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [IW-1:0]     upd_idx,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispredict,
  input  logic              inv_req,
  output logic              busy,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic                jmp_q   [ENTRIES];
  logic [1:0]          ctr_q   [ENTRIES];
  logic [TGT_W-1:0]    tgt_q   [ENTRIES];

  bp_state_e     state_q, state_d;
  logic [IW-1:0] walk_q, walk_d;

  logic [IW-1:0]       hist_c;
  logic [IW-1:0]       lk_idx_c;
  logic [TAG_BITS-1:0] lk_tag_c;
  logic [TAG_BITS-1:0] upd_tag_c;
  logic                accept_c;
  logic                upd_hit_c;
  logic                alloc_c;
  logic [1:0]          ctr_nxt_c;
  logic [STAT_W-1:0]   stat_br_d, stat_mis_d;
  logic                unused_c;

  assign busy      = (state_q == BP_INIT);
  assign accept_c  = upd_valid && !busy;
  assign upd_tag_c = upd_pc[IW+TAG_BITS+1:IW+2];
  assign upd_hit_c = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag_c);
  assign alloc_c   = accept_c && !upd_hit_c && upd_taken;
  assign unused_c  = ^{lk_pc, upd_pc, upd_target[1:0]};

  // Global history only exists in gshare mode; it trails committed branches.
  if (GHR_BITS > 0) begin : g_ghr
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    always_comb begin
      ghr_d = ghr_q;
      if (inv_req) begin
        ghr_d = '0;
      end else if (accept_c && !upd_is_jump) begin
        ghr_d = GHR_BITS'({ghr_q, upd_taken});
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ghr_q <= '0;
      end else begin
        ghr_q <= ghr_d;
      end
    end

    assign hist_c = IW'(ghr_q) << (IW - GHR_BITS);
  end else begin : g_bimodal
    assign hist_c = '0;
  end

  // Lookup path: zero latency, no bypass from a same-cycle update.
  assign lk_idx_c    = lk_pc[IW+1:2] ^ hist_c;
  assign lk_tag_c    = lk_pc[IW+TAG_BITS+1:IW+2];
  assign pred_idx    = lk_idx_c;
  assign pred_hit    = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c) && !busy;
  assign pred_taken  = pred_hit && (jmp_q[lk_idx_c] || ctr_q[lk_idx_c][1]);
  assign pred_target = pred_hit ? {tgt_q[lk_idx_c], 2'b00} : 32'h0;

  bp_sat_ctr #(.W(2)) u_dir_ctr (
    .cnt_i (ctr_q[upd_idx]),
    .inc_i (upd_taken),
    .dec_i (!upd_taken),
    .nxt_c (ctr_nxt_c)
  );

  bp_sat_ctr #(.W(STAT_W)) u_stat_br (
    .cnt_i (stat_branches),
    .inc_i (accept_c),
    .dec_i (1'b0),
    .nxt_c (stat_br_d)
  );

  bp_sat_ctr #(.W(STAT_W)) u_stat_mis (
    .cnt_i (stat_mispred),
    .inc_i (accept_c && upd_mispredict),
    .dec_i (1'b0),
    .nxt_c (stat_mis_d)
  );

  // Walker: one entry per cycle; inv_req restarts from entry 0.
  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    unique case (state_q)
      BP_IDLE: begin
        if (inv_req) begin
          state_d = BP_INIT;
          walk_d  = '0;
        end
      end
      BP_INIT: begin
        if (inv_req) begin
          walk_d = '0;
        end else if (walk_q == IW'(ENTRIES - 1)) begin
          state_d = BP_IDLE;
          walk_d  = '0;
        end else begin
          walk_d = walk_q + IW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BP_INIT;
      walk_q        <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      state_q       <= state_d;
      walk_q        <= walk_d;
      stat_branches <= stat_br_d;
      stat_mispred  <= stat_mis_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (busy) begin
      valid_q[walk_q] <= 1'b0;
    end else if (alloc_c) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; the walker seeds the counters.
  always_ff @(posedge clk) begin
    if (busy) begin
      ctr_q[walk_q] <= CTR_WNT;
    end else if (accept_c) begin
      if (upd_hit_c) begin
        if (!upd_is_jump) begin
          ctr_q[upd_idx] <= ctr_nxt_c;
        end
        if (upd_taken) begin
          tgt_q[upd_idx] <= upd_target[31:2];
        end
        jmp_q[upd_idx] <= upd_is_jump;
      end else if (upd_taken) begin
        tag_q[upd_idx] <= upd_tag_c;
        tgt_q[upd_idx] <= upd_target[31:2];
        jmp_q[upd_idx] <= upd_is_jump;
        ctr_q[upd_idx] <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: bimodal instance (default params) and gshare instance
// (GHR_BITS=4, STAT_W=4) checked against hand-computed expectations.
module tb_branch_predictor;

  logic clk;
  logic rst_n;

  logic [31:0] b_lk_pc, b_pred_target, b_upd_pc, b_upd_target;
  logic        b_pred_hit, b_pred_taken, b_upd_valid, b_upd_is_jump, b_upd_taken;
  logic        b_upd_mispredict, b_inv_req, b_busy;
  logic [5:0]  b_pred_idx, b_upd_idx;
  logic [31:0] b_stat_branches, b_stat_mispred;

  logic [31:0] g_lk_pc, g_pred_target, g_upd_pc, g_upd_target;
  logic        g_pred_hit, g_pred_taken, g_upd_valid, g_upd_is_jump, g_upd_taken;
  logic        g_upd_mispredict, g_inv_req, g_busy;
  logic [5:0]  g_pred_idx, g_upd_idx;
  logic [3:0]  g_stat_branches, g_stat_mispred;

  int tests = 0;
  int fails = 0;
  int exp_br = 0;
  int exp_mis = 0;
  int g_exp = 0;
  logic [3:0] ghr_m = 4'h0;

  branch_predictor u_bim (
    .clk(clk), .rst_n(rst_n), .lk_pc(b_lk_pc), .pred_hit(b_pred_hit),
    .pred_taken(b_pred_taken), .pred_target(b_pred_target), .pred_idx(b_pred_idx),
    .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_idx(b_upd_idx),
    .upd_is_jump(b_upd_is_jump), .upd_taken(b_upd_taken), .upd_target(b_upd_target),
    .upd_mispredict(b_upd_mispredict), .inv_req(b_inv_req), .busy(b_busy),
    .stat_branches(b_stat_branches), .stat_mispred(b_stat_mispred)
  );

  branch_predictor #(.ENTRIES(64), .TAG_BITS(8), .GHR_BITS(4), .STAT_W(4)) u_gsh (
    .clk(clk), .rst_n(rst_n), .lk_pc(g_lk_pc), .pred_hit(g_pred_hit),
    .pred_taken(g_pred_taken), .pred_target(g_pred_target), .pred_idx(g_pred_idx),
    .upd_valid(g_upd_valid), .upd_pc(g_upd_pc), .upd_idx(g_upd_idx),
    .upd_is_jump(g_upd_is_jump), .upd_taken(g_upd_taken), .upd_target(g_upd_target),
    .upd_mispredict(g_upd_mispredict), .inv_req(g_inv_req), .busy(g_busy),
    .stat_branches(g_stat_branches), .stat_mispred(g_stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_upd;
    logic [31:0] upc;
    logic        jmp;
    logic        tkn;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] lk;
    logic        e_hit;
    logic        e_tkn;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic du, input logic [31:0] upc, input logic j,
                              input logic t, input logic [31:0] tg, input logic m,
                              input logic [31:0] lk, input logic eh, input logic et,
                              input logic [31:0] etg);
    vec_t v;
    v.do_upd = du; v.upc = upc; v.jmp = j; v.tkn = t; v.tgt = tg; v.mis = m;
    v.lk = lk; v.e_hit = eh; v.e_tkn = et; v.e_tgt = etg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic b_drive(input logic [31:0] pc, input logic j, input logic t,
                         input logic [31:0] tg, input logic m);
    b_upd_valid = 1'b1; b_upd_pc = pc; b_upd_idx = pc[7:2];
    b_upd_is_jump = j; b_upd_taken = t; b_upd_target = tg; b_upd_mispredict = m;
    exp_br++;
    if (m) exp_mis++;
  endtask

  task automatic b_upd(input logic [31:0] pc, input logic j, input logic t,
                       input logic [31:0] tg, input logic m);
    b_drive(pc, j, t, tg, m);
    @(negedge clk);
    b_upd_valid = 1'b0;
  endtask

  task automatic g_upd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    g_upd_valid = 1'b1; g_upd_pc = pc; g_upd_idx = pc[7:2] ^ {ghr_m, 2'b00};
    g_upd_is_jump = 1'b0; g_upd_taken = t; g_upd_target = tg; g_upd_mispredict = 1'b1;
    g_exp++;
    ghr_m = {ghr_m[2:0], t};
    @(negedge clk);
    g_upd_valid = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; bounded so it cannot hang.
  task automatic count_busy(output int nb, output int ng, output logic hit_seen);
    nb = 0; ng = 0; hit_seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (b_busy) nb++;
      if (g_busy) ng++;
      if ((b_busy && b_pred_hit) || (g_busy && g_pred_hit)) hit_seen = 1'b1;
      if (!b_busy && !g_busy) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, ng;
    logic hs;

    rst_n = 1'b0;
    b_lk_pc = '0; b_upd_valid = 1'b0; b_upd_pc = '0; b_upd_idx = '0; b_upd_is_jump = 1'b0;
    b_upd_taken = 1'b0; b_upd_target = '0; b_upd_mispredict = 1'b0; b_inv_req = 1'b0;
    g_lk_pc = '0; g_upd_valid = 1'b0; g_upd_pc = '0; g_upd_idx = '0; g_upd_is_jump = 1'b0;
    g_upd_taken = 1'b0; g_upd_target = '0; g_upd_mispredict = 1'b0; g_inv_req = 1'b0;

    vecs[0]  = mk(1, 32'h100, 0, 1, 32'h80, 1, 32'h100, 1, 1, 32'h80);
    vecs[1]  = mk(1, 32'h100, 0, 0, 32'h0,  1, 32'h100, 1, 0, 32'h80);
    vecs[2]  = mk(1, 32'h100, 0, 0, 32'h0,  0, 32'h100, 1, 0, 32'h80);
    vecs[3]  = mk(1, 32'h100, 0, 0, 32'h0,  0, 32'h100, 1, 0, 32'h80);
    vecs[4]  = mk(1, 32'h100, 0, 1, 32'h88, 1, 32'h100, 1, 0, 32'h88);
    vecs[5]  = mk(1, 32'h100, 0, 1, 32'h88, 0, 32'h100, 1, 1, 32'h88);
    vecs[6]  = mk(1, 32'h100, 0, 1, 32'h88, 0, 32'h100, 1, 1, 32'h88);
    vecs[7]  = mk(1, 32'h100, 0, 1, 32'h88, 0, 32'h100, 1, 1, 32'h88);
    vecs[8]  = mk(1, 32'h100, 0, 0, 32'h0,  0, 32'h100, 1, 1, 32'h88);
    vecs[9]  = mk(1, 32'h104, 0, 0, 32'h0,  0, 32'h104, 0, 0, 32'h0);
    vecs[10] = mk(1, 32'h200, 0, 1, 32'h40, 1, 32'h100, 0, 0, 32'h0);
    vecs[11] = mk(0, 32'h0,   0, 0, 32'h0,  0, 32'h200, 1, 1, 32'h40);
    vecs[12] = mk(1, 32'h200, 0, 0, 32'h0,  0, 32'h200, 1, 0, 32'h40);
    vecs[13] = mk(1, 32'h200, 0, 0, 32'h0,  0, 32'h200, 1, 0, 32'h40);
    vecs[14] = mk(1, 32'h200, 1, 1, 32'h40, 1, 32'h200, 1, 1, 32'h40);
    vecs[15] = mk(0, 32'h0,   0, 0, 32'h0,  0, 32'h300, 0, 0, 32'h0);
    vecs[16] = mk(1, 32'h108, 0, 1, 32'h20, 0, 32'h108, 1, 1, 32'h20);

    // Reset state and initial walk
    repeat (2) @(negedge clk);
    chk("rst busy b", 32'(b_busy), 32'd1);
    chk("rst busy g", 32'(g_busy), 32'd1);
    chk("rst stat_br b", b_stat_branches, 32'd0);
    chk("rst stat_mis b", b_stat_mispred, 32'd0);
    rst_n = 1'b1;
    count_busy(nb, ng, hs);
    chk("init busy cycles b", 32'(nb), 32'd64);
    chk("init busy cycles g", 32'(ng), 32'd64);
    chk("hit during init", 32'(hs), 32'd0);
    b_lk_pc = 32'h100; #1;
    chk("hit after init", 32'(b_pred_hit), 32'd0);
    chk("stat_br after init", b_stat_branches, 32'd0);

    // Table-driven update/lookup sequence on the bimodal instance
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].do_upd) b_upd(vecs[i].upc, vecs[i].jmp, vecs[i].tkn, vecs[i].tgt, vecs[i].mis);
      b_lk_pc = vecs[i].lk; #1;
      chk($sformatf("vec%0d hit", i), 32'(b_pred_hit), 32'(vecs[i].e_hit));
      chk($sformatf("vec%0d taken", i), 32'(b_pred_taken), 32'(vecs[i].e_tkn));
      chk($sformatf("vec%0d target", i), b_pred_target, vecs[i].e_tgt);
    end
    chk("stat_br after vecs", b_stat_branches, 32'(exp_br));
    chk("stat_mis after vecs", b_stat_mispred, 32'(exp_mis));

    // Same-cycle update and lookup see the old contents
    @(negedge clk);
    b_drive(32'h108, 1'b0, 1'b0, 32'h0, 1'b0);
    b_lk_pc = 32'h108; #1;
    chk("same-cycle old taken", 32'(b_pred_taken), 32'd1);
    @(negedge clk); b_upd_valid = 1'b0; #1;
    chk("next-cycle new taken", 32'(b_pred_taken), 32'd0);
    @(negedge clk);
    b_drive(32'h10C, 1'b0, 1'b1, 32'h30, 1'b0);
    b_lk_pc = 32'h10C; #1;
    chk("same-cycle alloc hit", 32'(b_pred_hit), 32'd0);
    @(negedge clk); b_upd_valid = 1'b0; #1;
    chk("alloc hit", 32'(b_pred_hit), 32'd1);
    chk("alloc target", b_pred_target, 32'h30);
    chk("alloc idx", 32'(b_pred_idx), 32'd3);

    // Invalidate, restart mid-walk, updates dropped while busy
    @(negedge clk); b_inv_req = 1'b1;
    @(negedge clk); b_inv_req = 1'b0;
    b_lk_pc = 32'h200; #1;
    chk("inv busy", 32'(b_busy), 32'd1);
    chk("inv hit gated", 32'(b_pred_hit), 32'd0);
    repeat (30) @(negedge clk);
    b_inv_req = 1'b1;
    b_upd_valid = 1'b1; b_upd_pc = 32'h400; b_upd_idx = 6'd0; b_upd_is_jump = 1'b0;
    b_upd_taken = 1'b1; b_upd_target = 32'h44; b_upd_mispredict = 1'b1;
    @(negedge clk); b_inv_req = 1'b0;
    count_busy(nb, ng, hs);
    b_upd_valid = 1'b0;
    chk("restart busy cycles", 32'(nb), 32'd64);
    chk("hit during restart", 32'(hs), 32'd0);
    chk("stat_br frozen", b_stat_branches, 32'(exp_br));
    chk("stat_mis frozen", b_stat_mispred, 32'(exp_mis));
    b_lk_pc = 32'h200; #1;
    chk("post-inv hit 0x200", 32'(b_pred_hit), 32'd0);
    b_lk_pc = 32'h400; #1;
    chk("post-inv hit 0x400", 32'(b_pred_hit), 32'd0);

    // gshare history T,T,N,T -> 1101
    @(negedge clk);
    g_upd(32'h1000, 1'b1, 32'h700);
    g_upd(32'h1000, 1'b1, 32'h700);
    g_upd(32'h1000, 1'b0, 32'h0);
    g_upd(32'h1000, 1'b1, 32'h700);
    g_lk_pc = 32'h0; #1;
    chk("gshare idx pc0", 32'(g_pred_idx), 32'h34);
    chk("gshare miss pc0", 32'(g_pred_hit), 32'd0);
    @(negedge clk);
    g_upd(32'h0, 1'b1, 32'h500);
    g_lk_pc = 32'h60; #1;
    chk("gshare alias idx", 32'(g_pred_idx), 32'h34);
    chk("gshare alias hit", 32'(g_pred_hit), 32'd1);
    chk("gshare alias taken", 32'(g_pred_taken), 32'd1);
    chk("gshare alias target", g_pred_target, 32'h500);
    g_lk_pc = 32'h0; #1;
    chk("gshare pc0 new idx", 32'(g_pred_idx), 32'h2C);
    chk("gshare pc0 new hit", 32'(g_pred_hit), 32'd0);
    chk("g stat_br 5", 32'(g_stat_branches), 32'(g_exp));

    // Saturating 4-bit stats
    @(negedge clk);
    for (int i = 0; i < 20; i++) g_upd(32'h2000, 1'b0, 32'h0);
    chk("g stat_br sat", 32'(g_stat_branches), 32'd15);
    chk("g stat_mis sat", 32'(g_stat_mispred), 32'd15);

    // inv_req keeps stats; async reset mid-walk clears them and restarts
    g_inv_req = 1'b1;
    @(negedge clk); g_inv_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("g busy mid-walk", 32'(g_busy), 32'd1);
    chk("g stat kept by inv", 32'(g_stat_branches), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst g stat_br", 32'(g_stat_branches), 32'd0);
    chk("async rst g stat_mis", 32'(g_stat_mispred), 32'd0);
    chk("async rst b stat_br", b_stat_branches, 32'd0);
    chk("async rst b busy", 32'(b_busy), 32'd1);
    #1 rst_n = 1'b1;
    count_busy(nb, ng, hs);
    chk("post-rst busy cycles g", 32'(ng), 32'd64);
    chk("post-rst busy cycles b", 32'(nb), 32'd64);
    g_lk_pc = 32'h60; #1;
    chk("post-rst g hit", 32'(g_pred_hit), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
